// File: rtl/sobel_stream_filter.sv
// 3x3 streaming Sobel edge filter with two internal line buffers and a fixed 2-cycle latency.
// Optional build macro SOBEL_THRESH_EN binarises filtered outputs against iTHRESH.
module sobel_stream_filter #(
   parameter int DW       = 12,
   parameter int LINE_LEN = 640,
   parameter int COL_W    = 10
) (
   input  logic          iCLK,
   input  logic          iRST_N,
   input  logic          iSOF,
   input  logic [DW-1:0] iDATA,
   input  logic          iDVAL,
   input  logic [1:0]    iMODE,
   input  logic [DW-1:0] iTHRESH,
   output logic [DW-1:0] oDATA,
   output logic          oDVAL,
   output logic [1:0]    oMODE
);

   localparam int GW = DW + 3;
   localparam int MW = DW + 4;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_LEN - 1);
   localparam logic [DW-1:0]    PIX_MAX  = '1;

   typedef enum logic [1:0] {
      MODE_PASS = 2'd0,
      MODE_GX   = 2'd1,
      MODE_GY   = 2'd2,
      MODE_SUM  = 2'd3
   } mode_e;

   logic [COL_W-1:0] col_q, col_d, col_cur;
   logic [1:0]       row_q, row_d, row_cur;
   mode_e            mode_q, mode_d;

   logic [DW-1:0] line1_mem_q [LINE_LEN];
   logic [DW-1:0] line2_mem_q [LINE_LEN];
   logic [DW-1:0] p02, p12, p22;

   logic [DW-1:0] p00_q, p10_q, p20_q, p01_q, p11_q, p21_q;
   logic [DW-1:0] p00_d, p10_d, p20_d, p01_d, p11_d, p21_d;

   logic                 s1_vld_q, s1_vld_d;
   logic signed [GW-1:0] s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
   logic [DW-1:0]        s1_pix_q, s1_pix_d;
   logic                 s1_border_q, s1_border_d;
   mode_e                s1_mode_q, s1_mode_d;

   logic [GW-1:0] abs_x, abs_y;
   logic [MW-1:0] mag;
   logic [DW-1:0] sat, filt;
   logic [DW-1:0] data_q, data_d;
   logic          dval_q, dval_d;

   function automatic logic signed [GW-1:0] ext(input logic [DW-1:0] p);
      return $signed({3'b000, p});
   endfunction

   // iSOF overrides the stored position so the pixel arriving with it lands at row 0, col 0.
   always_comb begin
      col_cur = iSOF ? '0 : col_q;
      row_cur = iSOF ? 2'd0 : row_q;
      mode_d  = iSOF ? mode_e'(iMODE) : mode_q;
      col_d   = col_cur;
      row_d   = row_cur;
      if (iDVAL) begin
         if (col_cur == LAST_COL) begin
            col_d = '0;
            if (row_cur != 2'd3) row_d = row_cur + 2'd1;
         end else begin
            col_d = col_cur + COL_W'(1);
         end
      end
   end

   assign p02 = line2_mem_q[col_cur];
   assign p12 = line1_mem_q[col_cur];
   assign p22 = iDATA;

   always_ff @(posedge iCLK) begin
      if (iDVAL) begin
         line1_mem_q[col_cur] <= iDATA;
         line2_mem_q[col_cur] <= p12;
      end
   end

   // Stage 1: shift the window one column and form the signed gradients.
   always_comb begin
      p00_d       = p00_q;
      p10_d       = p10_q;
      p20_d       = p20_q;
      p01_d       = p01_q;
      p11_d       = p11_q;
      p21_d       = p21_q;
      s1_vld_d    = iDVAL;
      s1_gx_d     = s1_gx_q;
      s1_gy_d     = s1_gy_q;
      s1_pix_d    = s1_pix_q;
      s1_border_d = s1_border_q;
      s1_mode_d   = s1_mode_q;
      if (iDVAL) begin
         p00_d       = p01_q;
         p10_d       = p11_q;
         p20_d       = p21_q;
         p01_d       = p02;
         p11_d       = p12;
         p21_d       = p22;
         s1_gx_d     = (ext(p02) + (ext(p12) <<< 1) + ext(p22))
                     - (ext(p00_q) + (ext(p10_q) <<< 1) + ext(p20_q));
         s1_gy_d     = (ext(p20_q) + (ext(p21_q) <<< 1) + ext(p22))
                     - (ext(p00_q) + (ext(p01_q) <<< 1) + ext(p02));
         s1_pix_d    = iDATA;
         s1_border_d = (row_cur < 2'd2) || (col_cur < COL_W'(2));
         s1_mode_d   = mode_d;
      end
   end

   // Stage 2: magnitude, saturation and the border/pass selection.
   always_comb begin
      abs_x = s1_gx_q[GW-1] ? GW'(-s1_gx_q) : GW'(s1_gx_q);
      abs_y = s1_gy_q[GW-1] ? GW'(-s1_gy_q) : GW'(s1_gy_q);
      case (s1_mode_q)
         MODE_GX: mag = {1'b0, abs_x};
         MODE_GY: mag = {1'b0, abs_y};
         default: mag = {1'b0, abs_x} + {1'b0, abs_y};
      endcase
      sat = (mag > {{(MW-DW){1'b0}}, PIX_MAX}) ? PIX_MAX : mag[DW-1:0];
`ifdef SOBEL_THRESH_EN
      filt = s1_border_q ? '0 : ((sat >= iTHRESH) ? PIX_MAX : '0);
`else
      filt = s1_border_q ? '0 : sat;
`endif
      dval_d = s1_vld_q;
      data_d = data_q;
      if (s1_vld_q) data_d = (s1_mode_q == MODE_PASS) ? s1_pix_q : filt;
   end

`ifndef SOBEL_THRESH_EN
   logic unused_thresh;
   assign unused_thresh = ^iTHRESH;
`endif

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         col_q       <= '0;
         row_q       <= '0;
         mode_q      <= MODE_PASS;
         p00_q       <= '0;
         p10_q       <= '0;
         p20_q       <= '0;
         p01_q       <= '0;
         p11_q       <= '0;
         p21_q       <= '0;
         s1_vld_q    <= 1'b0;
         s1_gx_q     <= '0;
         s1_gy_q     <= '0;
         s1_pix_q    <= '0;
         s1_border_q <= 1'b1;
         s1_mode_q   <= MODE_PASS;
         data_q      <= '0;
         dval_q      <= 1'b0;
      end else begin
         col_q       <= col_d;
         row_q       <= row_d;
         mode_q      <= mode_d;
         p00_q       <= p00_d;
         p10_q       <= p10_d;
         p20_q       <= p20_d;
         p01_q       <= p01_d;
         p11_q       <= p11_d;
         p21_q       <= p21_d;
         s1_vld_q    <= s1_vld_d;
         s1_gx_q     <= s1_gx_d;
         s1_gy_q     <= s1_gy_d;
         s1_pix_q    <= s1_pix_d;
         s1_border_q <= s1_border_d;
         s1_mode_q   <= s1_mode_d;
         data_q      <= data_d;
         dval_q      <= dval_d;
      end
   end

   assign oDATA = data_q;
   assign oDVAL = dval_q;
   assign oMODE = mode_q;

endmodule

// File: tb/tb_sobel_stream_filter.sv
// Scoreboard bench for sobel_stream_filter: a frame-array reference model predicts each output pixel.
module tb_sobel_stream_filter;

   localparam int DW   = 12;
   localparam int L    = 8;
   localparam int CW   = 3;
   localparam int MAXV = 4095;

   logic          iCLK    = 1'b0;
   logic          iRST_N  = 1'b1;
   logic          iSOF    = 1'b0;
   logic          iDVAL   = 1'b0;
   logic [DW-1:0] iDATA   = '0;
   logic [1:0]    iMODE   = 2'd0;
   logic [DW-1:0] iTHRESH = 12'd2000;
   logic [DW-1:0] oDATA;
   logic          oDVAL;
   logic [1:0]    oMODE;

   sobel_stream_filter #(.DW(DW), .LINE_LEN(L), .COL_W(CW)) dut (
      .iCLK(iCLK), .iRST_N(iRST_N), .iSOF(iSOF), .iDATA(iDATA), .iDVAL(iDVAL),
      .iMODE(iMODE), .iTHRESH(iTHRESH), .oDATA(oDATA), .oDVAL(oDVAL), .oMODE(oMODE)
   );

   always #5 iCLK = ~iCLK;

   int cyc = 0;
   always @(posedge iCLK) cyc++;

   typedef struct {
      int data;
      int issue;
   } exp_t;

   exp_t exp_q[$];
   int   fpix[$];
   int   fmode    = 0;
   int   out_cnt  = 0;
   int   checks   = 0;
   int   failures = 0;

   // Reference: each pixel is filtered from the frame's own pixel history by raster index.
   function automatic int refPixel(input int n);
      int r, c, gx, gy, ax, ay, mag;
      int p[3][3];
      r = n / L;
      c = n % L;
      if (fmode == 0) return fpix[n];
      if (r < 2 || c < 2) return 0;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++)
            p[i][j] = fpix[n - (2 - i) * L - (2 - j)];
      gx = (p[0][2] + 2 * p[1][2] + p[2][2]) - (p[0][0] + 2 * p[1][0] + p[2][0]);
      gy = (p[2][0] + 2 * p[2][1] + p[2][2]) - (p[0][0] + 2 * p[0][1] + p[0][2]);
      ax = (gx < 0) ? -gx : gx;
      ay = (gy < 0) ? -gy : gy;
      mag = (fmode == 1) ? ax : (fmode == 2) ? ay : ax + ay;
      if (mag > MAXV) mag = MAXV;
`ifdef SOBEL_THRESH_EN
      mag = (mag >= int'(iTHRESH)) ? MAXV : 0;
`endif
      return mag;
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs (called just after a rising edge) and records the prediction.
   task automatic applyStimulus(input bit sof, input bit dval, input int data);
      exp_t e;
      iSOF  = sof;
      iDVAL = dval;
      iDATA = DW'(data);
      if (iRST_N) begin
         if (sof) begin
            fpix.delete();
            fmode = int'(iMODE);
         end
         if (dval) begin
            fpix.push_back(data);
            e.data  = refPixel(fpix.size() - 1);
            e.issue = cyc;
            exp_q.push_back(e);
         end
      end
      @(posedge iCLK);
      #1;
      iSOF  = 1'b0;
      iDVAL = 1'b0;
   endtask

   // sofKind: 0 = iSOF with first pixel, 1 = iSOF alone before the frame, 2 = no iSOF.
   task automatic sendFrame(input int mode, input int kind, input int npix, input int gapmax,
                            input int sofKind);
      int data, col;
      if (sofKind != 2) iMODE = 2'(mode);
      if (sofKind == 1) applyStimulus(1'b1, 1'b0, 0);
      for (int n = 0; n < npix; n++) begin
         repeat ($urandom_range(0, gapmax)) applyStimulus(1'b0, 1'b0, 0);
         col = n % L;
         case (kind)
            0:       data = 100;
            1:       data = (col < 4) ? 0 : 1000;
            2:       data = (col < 4) ? 0 : 2000;
            3:       data = int'($urandom_range(0, MAXV));
            default: data = int'($urandom_range(0, 300));
         endcase
         applyStimulus((n == 0) && (sofKind == 0), 1'b1, data);
      end
   endtask

   task automatic drain(input string name);
      repeat (4) applyStimulus(1'b0, 1'b0, 0);
      checkOutput(name, exp_q.size(), 0);
   endtask

   // Monitor: every presented output must match the oldest prediction, exactly 2 cycles late.
   always @(negedge iCLK) begin
      exp_t e;
      if (iRST_N && oDVAL) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_oDVAL", 1, 0);
         end else begin
            e = exp_q.pop_front();
            checkOutput("oDATA", int'(oDATA), e.data);
            checkOutput("latency", cyc - e.issue, 2);
            out_cnt++;
         end
      end
   end

   initial begin
      $display("[TB] start");
      #2 iRST_N = 1'b0;
      @(posedge iCLK);
      #1;
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b0, 1'(i % 2), 37 * i + 5);
         checkOutput("reset_oDVAL", int'(oDVAL), 0);
         checkOutput("reset_oDATA", int'(oDATA), 0);
      end
      checkOutput("reset_oMODE", int'(oMODE), 0);
      iRST_N = 1'b1;

      $display("[TB] flat frame, mode 3");
      out_cnt = 0;
      sendFrame(3, 0, 4 * L, 0, 0);
      drain("flat_drain");
      checkOutput("flat_count", out_cnt, 32);

      $display("[TB] vertical step frames");
      sendFrame(1, 1, 4 * L, 0, 0);
      sendFrame(2, 1, 4 * L, 0, 0);
      sendFrame(1, 2, 4 * L, 1, 0);
      sendFrame(3, 2, 5 * L, 1, 1);
      drain("step_drain");

      $display("[TB] pass mode with gaps");
      out_cnt = 0;
      sendFrame(0, 3, 4 * L, 3, 0);
      drain("pass_drain");
      checkOutput("pass_count", out_cnt, 32);

      $display("[TB] random frames");
      for (int f = 0; f < 8; f++) begin
         sendFrame(int'($urandom_range(0, 3)), int'($urandom_range(3, 4)),
                   int'($urandom_range(3 * L, 6 * L + 5)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 1)));
      end
      drain("random_drain");

      $display("[TB] mode change mid-frame");
      sendFrame(1, 4, 2 * L + 3, 1, 0);
      iMODE = 2'd2;
      sendFrame(2, 4, 5, 1, 2);
      checkOutput("oMODE_hold", int'(oMODE), 1);
      applyStimulus(1'b1, 1'b1, 250);
      checkOutput("oMODE_new", int'(oMODE), 2);
      sendFrame(2, 4, 3 * L, 0, 2);
      drain("mode_drain");

      $display("[TB] reset mid-frame");
      sendFrame(3, 3, 2 * L + 4, 0, 0);
      applyStimulus(1'b0, 1'b1, 777);
      iRST_N = 1'b0;
      exp_q.delete();
      fpix.delete();
      fmode = 0;
      #1;
      checkOutput("midreset_oDVAL", int'(oDVAL), 0);
      checkOutput("midreset_oDATA", int'(oDATA), 0);
      checkOutput("midreset_oMODE", int'(oMODE), 0);
      applyStimulus(1'b0, 1'b1, 123);
      applyStimulus(1'b0, 1'b1, 456);
      checkOutput("midreset_hold_oDVAL", int'(oDVAL), 0);
      iRST_N = 1'b1;
      out_cnt = 0;
      sendFrame(0, 3, 3 * L + 2, 1, 2);
      drain("postreset_drain");
      checkOutput("postreset_count", out_cnt, 3 * L + 2);
      sendFrame(3, 3, 4 * L, 0, 0);
      drain("final_drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
